// File: rtl/board_game_pkg.sv
// Shared board geometry, sequencer state encoding and tile-to-screen mapping.
// Latency: n/a (constants, types and a combinational helper only).
// Backpressure: n/a.
package board_game_pkg;

  localparam logic [9:0] START_X   = 10'd20;  // x of tile 0
  localparam logic [9:0] TILE_STEP = 10'd40;  // pixels per tile
  localparam logic [3:0] LAST_TILE = 4'd15;   // flag tile, x = 620

  typedef enum logic [3:0] {
    WAIT_ROLL,
    ISSUE,
    WAIT_DONE,
    CHECK_END,
    RST_P1,
    RST_P1_WAIT,
    RST_P2,
    RST_P2_WAIT,
    GAME_OVER
  } seq_state_t;

  // Screen x coordinate of a tile; the flag tile lands on 620, inside 10 bits.
  function automatic logic [9:0] tile_to_x(input logic [3:0] tile);
    return START_X + TILE_STEP * {6'd0, tile};
  endfunction

endpackage

// File: rtl/dice_counter.sv
// Free-running die: cycles 1..6 every clock, value held in a register.
// Latency: value is registered; the roll sampler reads it combinationally.
// Backpressure: none, never stalls.
module dice_counter (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] value
);

  // Advance 1,2,...,6,1,... every clock; reset restarts at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 3'd1;
    end else if (value == 3'd6) begin
      value <= 3'd1;
    end else begin
      value <= value + 3'd1;
    end
  end

endmodule

// File: rtl/board_turn_sequencer.sv
// Two-player turn sequencer: roll on button edge, move tile, issue target x, alternate turns.
// Latency: roll edge cycle N -> pos_valid cycle N+1; turn_done cycle T -> next roll accepted in T+2.
// Backpressure: waits on the mover's turn_done (or WAIT_TIMEOUT); edges outside idle states dropped.
// Build option: define BOARD_EXACT_FINISH_EN to bounce overshooting moves back off the flag tile.
module board_turn_sequencer
  import board_game_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       roll_req,
  input  logic       new_game,
  input  logic       player1_turn_done,
  input  logic       player2_turn_done,
  output logic [9:0] player1_pos_x,
  output logic       player1_pos_valid,
  output logic [9:0] player2_pos_x,
  output logic       player2_pos_valid,
  output logic       current_player,
  output logic [2:0] dice_value,
  output logic [3:0] p1_tile,
  output logic [3:0] p2_tile,
  output logic       busy,
  output logic       game_over,
  output logic       winner,
  output logic       timeout_err
);

  localparam int             TW       = (WAIT_TIMEOUT > 2) ? $clog2(WAIT_TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(WAIT_TIMEOUT - 1);

  seq_state_t    state, state_n;
  logic          roll_prev, ng_prev;
  logic          roll_edge, ng_edge;
  logic [2:0]    dice_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          in_wait;
  logic          cur_done;
  logic [3:0]    cur_tile;
  logic [4:0]    step_sum;
  logic [3:0]    rolled_tile;

  dice_counter u_dice (
    .clk   (clk),
    .rst   (rst),
    .value (dice_cnt)
  );

  assign roll_edge = roll_req & ~roll_prev;
  assign ng_edge   = new_game & ~ng_prev;
  assign cur_done  = current_player ? player2_turn_done : player1_turn_done;
  assign cur_tile  = current_player ? p2_tile : p1_tile;
  assign in_wait   = state inside {WAIT_DONE, RST_P1_WAIT, RST_P2_WAIT};
  assign tmo_hit   = in_wait && (tmo_cnt == TMO_LAST);

  // Five-bit sum so a roll from tile 14/15 cannot wrap before the finish rule.
  assign step_sum = {1'b0, cur_tile} + {2'b0, dice_cnt};
`ifdef BOARD_EXACT_FINISH_EN
  assign rolled_tile = (step_sum > {1'b0, LAST_TILE}) ? 4'({LAST_TILE, 1'b0} - step_sum)
                                                      : step_sum[3:0];
`else
  assign rolled_tile = (step_sum > {1'b0, LAST_TILE}) ? LAST_TILE : step_sum[3:0];
`endif

  // Button history for rising-edge detection, updated every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      roll_prev <= 1'b0;
      ng_prev   <= 1'b0;
    end else begin
      roll_prev <= roll_req;
      ng_prev   <= new_game;
    end
  end

  // Timeout counter runs only while waiting on a mover and restarts on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (!in_wait) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= WAIT_ROLL;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, move pulses and busy; pulses are Moore outputs of one-cycle states.
  always_comb begin
    state_n           = state;
    player1_pos_valid = 1'b0;
    player2_pos_valid = 1'b0;
    busy              = 1'b1;
    case (state)
      WAIT_ROLL: begin
        busy = 1'b0;
        if (ng_edge) begin
          state_n = RST_P1;
        end else if (roll_edge) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        player1_pos_valid = ~current_player;
        player2_pos_valid = current_player;
        state_n           = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (cur_done || tmo_hit) begin
          state_n = CHECK_END;
        end
      end
      CHECK_END: begin
        state_n = (cur_tile == LAST_TILE) ? GAME_OVER : WAIT_ROLL;
      end
      GAME_OVER: begin
        busy = 1'b0;
        if (ng_edge) begin
          state_n = RST_P1;
        end
      end
      RST_P1: begin
        player1_pos_valid = 1'b1;
        state_n           = RST_P1_WAIT;
      end
      RST_P1_WAIT: begin
        if (player1_turn_done || tmo_hit) begin
          state_n = RST_P2;
        end
      end
      RST_P2: begin
        player2_pos_valid = 1'b1;
        state_n           = RST_P2_WAIT;
      end
      RST_P2_WAIT: begin
        if (player2_turn_done || tmo_hit) begin
          state_n = WAIT_ROLL;
        end
      end
      default: state_n = WAIT_ROLL;
    endcase
  end

  // Game datapath: tiles and target x are loaded on the transition into the pulse state,
  // so pos_x is already stable in the cycle its pos_valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_tile        <= 4'd0;
      p2_tile        <= 4'd0;
      player1_pos_x  <= START_X;
      player2_pos_x  <= START_X;
      current_player <= 1'b0;
      dice_value     <= 3'd0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        WAIT_ROLL: begin
          if (ng_edge) begin
            p1_tile       <= 4'd0;
            player1_pos_x <= START_X;
          end else if (roll_edge) begin
            dice_value <= dice_cnt;
            if (current_player) begin
              p2_tile       <= rolled_tile;
              player2_pos_x <= tile_to_x(rolled_tile);
            end else begin
              p1_tile       <= rolled_tile;
              player1_pos_x <= tile_to_x(rolled_tile);
            end
          end
        end
        WAIT_DONE: begin
          if (!cur_done && tmo_hit) begin
            timeout_err <= 1'b1;
          end
        end
        CHECK_END: begin
          if (cur_tile == LAST_TILE) begin
            winner    <= current_player;
            game_over <= 1'b1;
          end else begin
            current_player <= ~current_player;
          end
        end
        GAME_OVER: begin
          if (ng_edge) begin
            p1_tile       <= 4'd0;
            player1_pos_x <= START_X;
          end
        end
        RST_P1_WAIT: begin
          if (player1_turn_done || tmo_hit) begin
            p2_tile       <= 4'd0;
            player2_pos_x <= START_X;
          end
        end
        RST_P2_WAIT: begin
          if (player2_turn_done || tmo_hit) begin
            current_player <= 1'b0;
            game_over      <= 1'b0;
            dice_value     <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_turn_sequencer.sv
// Directed bench for board_turn_sequencer with WAIT_TIMEOUT = 100.
// Expected values are hand-derived from cycle timing and the board rules.
// Build option: BOARD_EXACT_FINISH_EN switches the overshoot expectations.
module tb_board_turn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       roll_req, new_game;
  logic       player1_turn_done, player2_turn_done;
  logic [9:0] player1_pos_x, player2_pos_x;
  logic       player1_pos_valid, player2_pos_valid;
  logic       current_player;
  logic [2:0] dice_value;
  logic [3:0] p1_tile, p2_tile;
  logic       busy, game_over, winner, timeout_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int n1 = 0, n2 = 0;
  logic both_hi = 1'b0;

  int exp_cur = 0, exp_t1 = 0, exp_t2 = 0, exp_dice = 0;

  board_turn_sequencer #(.WAIT_TIMEOUT(100)) dut (
    .clk               (clk),
    .rst               (rst),
    .roll_req          (roll_req),
    .new_game          (new_game),
    .player1_turn_done (player1_turn_done),
    .player2_turn_done (player2_turn_done),
    .player1_pos_x     (player1_pos_x),
    .player1_pos_valid (player1_pos_valid),
    .player2_pos_x     (player2_pos_x),
    .player2_pos_valid (player2_pos_valid),
    .current_player    (current_player),
    .dice_value        (dice_value),
    .p1_tile           (p1_tile),
    .p2_tile           (p2_tile),
    .busy              (busy),
    .game_over         (game_over),
    .winner            (winner),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; the die reads (cyc % 6) + 1 at posedge number cyc.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Pulse monitor.
  always @(negedge clk) begin
    if (player1_pos_valid) n1 <= n1 + 1;
    if (player2_pos_valid) n2 <= n2 + 1;
    if (player1_pos_valid && player2_pos_valid) both_hi <= 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int next_tile(input int t, input int d);
    int s;
    s = t + d;
`ifdef BOARD_EXACT_FINISH_EN
    return (s > 15) ? 30 - s : s;
`else
    return (s > 15) ? 15 : s;
`endif
  endfunction

  // Roll on the posedge where the die shows want (0 = next posedge); leaves us in ISSUE.
  task automatic do_roll(input int want, input bit hold, output int d);
    for (int i = 0; i < 6 && want != 0 && ((cyc % 6) + 1) != want; i++) @(negedge clk);
    d = (cyc % 6) + 1;
    roll_req = 1'b1;
    @(negedge clk);
    if (!hold) roll_req = 1'b0;
  endtask

  task automatic check_issue(input int d);
    int t;
    if (exp_cur == 0) exp_t1 = next_tile(exp_t1, d);
    else              exp_t2 = next_tile(exp_t2, d);
    exp_dice = d;
    t = (exp_cur == 0) ? exp_t1 : exp_t2;
    chk("issue_dice", 32'(dice_value), d);
    chk("issue_p1_vld", 32'(player1_pos_valid), (exp_cur == 0) ? 1 : 0);
    chk("issue_p2_vld", 32'(player2_pos_valid), (exp_cur == 1) ? 1 : 0);
    chk("issue_tile", (exp_cur == 0) ? 32'(p1_tile) : 32'(p2_tile), t);
    chk("issue_x", (exp_cur == 0) ? 32'(player1_pos_x) : 32'(player2_pos_x), 20 + 40 * t);
    chk("issue_busy", 32'(busy), 1);
  endtask

  task automatic pulse_done(input int p);
    if (p == 0) player1_turn_done = 1'b1;
    else        player2_turn_done = 1'b1;
    @(negedge clk);
    player1_turn_done = 1'b0;
    player2_turn_done = 1'b0;
  endtask

  task automatic play(input int want, input int hold);
    int d, t;
    do_roll(want, 1'b0, d);
    check_issue(d);
    repeat (hold) @(negedge clk);
    pulse_done(exp_cur);
    @(negedge clk);
    t = (exp_cur == 0) ? exp_t1 : exp_t2;
    if (t == 15) begin
      chk("end_game_over", 32'(game_over), 1);
      chk("end_winner", 32'(winner), exp_cur);
      chk("end_busy", 32'(busy), 0);
    end else begin
      exp_cur ^= 1;
      chk("turn_cur", 32'(current_player), exp_cur);
      chk("turn_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    int d;
    rst = 1'b1;
    roll_req = 1'b0;
    new_game = 1'b0;
    player1_turn_done = 1'b0;
    player2_turn_done = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_p1_x", 32'(player1_pos_x), 20);
    chk("rst_p2_x", 32'(player2_pos_x), 20);
    chk("rst_vld", 32'({player1_pos_valid, player2_pos_valid}), 0);
    chk("rst_tiles", 32'({p1_tile, p2_tile}), 0);
    chk("rst_dice", 32'(dice_value), 0);
    chk("rst_flags", 32'({current_player, busy, game_over, winner, timeout_err}), 0);
    rst = 1'b0;

    // P1 rolls with the edge on cycle 2 -> die 3, tile 3, x 140.
    do_roll(3, 1'b0, d);
    chk("t1_dice3", 32'(dice_value), 3);
    chk("t1_x140", 32'(player1_pos_x), 140);
    check_issue(d);
    @(negedge clk);
    chk("t1_vld_single", 32'(player1_pos_valid), 0);
    repeat (20) @(negedge clk);
    pulse_done(1);
    chk("p2_done_ign_busy", 32'(busy), 1);
    @(negedge clk);
    chk("p2_done_ign_busy2", 32'(busy), 1);
    chk("p2_done_ign_cur", 32'(current_player), 0);
    roll_req = 1'b1;
    @(negedge clk);
    roll_req = 1'b0;
    @(negedge clk);
    chk("wait_roll_dice", 32'(dice_value), 3);
    chk("wait_roll_tile", 32'(p1_tile), 3);
    chk("wait_roll_npulse", n1, 1);
    repeat (25) @(negedge clk);
    pulse_done(0);
    @(negedge clk);
    exp_cur = 1;
    chk("t1_cur_p2", 32'(current_player), 1);
    chk("t1_no_p2_pulse", n2, 0);

    // P2 rolls on the first permitted cycle and keeps the button held.
    do_roll(0, 1'b1, d);
    check_issue(d);
    repeat (3) @(negedge clk);
    pulse_done(1);
    @(negedge clk);
    exp_cur = 0;
    chk("t2_cur_p1", 32'(current_player), 0);
    repeat (3) @(negedge clk);
    chk("held_no_reroll_busy", 32'(busy), 0);
    chk("held_no_reroll_dice", 32'(dice_value), exp_dice);
    roll_req = 1'b0;
    @(negedge clk);

    play(6, 2);                          // P1 -> 9

    // P2 turn with turn_done withheld: timeout after 100 cycles in WAIT_DONE.
    do_roll(1, 1'b0, d);
    check_issue(d);
    repeat (100) @(negedge clk);
    chk("tmo_not_yet", 32'(timeout_err), 0);
    @(negedge clk);
    chk("tmo_set", 32'(timeout_err), 1);
    @(negedge clk);
    exp_cur = 0;
    chk("tmo_turn_passes", 32'(current_player), 0);

    play(4, 1);                          // P1 -> 13
    play(1, 1);                          // P2 +1
    play(6, 1);                          // P1 overshoot: 15 (clamp) or 11 (bounce)

`ifndef BOARD_EXACT_FINISH_EN
    roll_req = 1'b1;
    @(negedge clk);
    roll_req = 1'b0;
    @(negedge clk);
    chk("over_roll_ign_go", 32'(game_over), 1);
    chk("over_roll_ign_dice", 32'(dice_value), 6);
    chk("over_roll_ign_tile", 32'(p1_tile), 15);
`endif

    // New game with a simultaneous roll: new game wins.
    new_game = 1'b1;
    roll_req = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    roll_req = 1'b0;
    chk("ng_p1_vld", 32'(player1_pos_valid), 1);
    chk("ng_p1_x", 32'(player1_pos_x), 20);
    chk("ng_p2_vld0", 32'(player2_pos_valid), 0);
    chk("ng_prio_dice", 32'(dice_value), 6);
    repeat (4) @(negedge clk);
    chk("ng_p2_waits", 32'(player2_pos_valid), 0);
    pulse_done(0);
    chk("ng_p2_vld", 32'(player2_pos_valid), 1);
    chk("ng_p2_x", 32'(player2_pos_x), 20);
    chk("ng_p1_vld0", 32'(player1_pos_valid), 0);
    repeat (2) @(negedge clk);
    pulse_done(1);
    chk("ng_tiles", 32'({p1_tile, p2_tile}), 0);
    chk("ng_cur", 32'(current_player), 0);
    chk("ng_game_over", 32'(game_over), 0);
    chk("ng_dice", 32'(dice_value), 0);
    chk("ng_busy", 32'(busy), 0);
    chk("ng_tmo_sticky", 32'(timeout_err), 1);

    // Async reset in the middle of a new-game walk.
    exp_cur = 0; exp_t1 = 0; exp_t2 = 0;
    play(2, 1);
    play(3, 1);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    @(negedge clk);
    chk("pre_rst_p2_tile", 32'(p2_tile), 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_p2_tile", 32'(p2_tile), 0);
    chk("mid_rst_p2_x", 32'(player2_pos_x), 20);
    chk("mid_rst_dice", 32'(dice_value), 0);
    chk("mid_rst_flags", 32'({current_player, busy, game_over, timeout_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("never_both_valid", 32'(both_hi), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
